bist_sig_checker: RTL

- Response-side reader for the LBIST datapath: consumes the MISR signature at the end of every seed session and compares it against a per-session golden value fetched from a golden-signature ROM.
- Records a per-session fail map and the first failing session.
- Unloads the fail map and the final signature to the tester over a 1-bit valid/ready serial link.
- Sits beside the BIST controller, fed by the MISR and the controller's session/end pulses.

---
 rtl/bist_pkg.sv | 17 +
 rtl/bist_ser_tx.sv | 59 +++++
 rtl/bist_sig_checker.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/bist_pkg.sv
// Shared sizes and checker state encoding for the LBIST response side.
// Imported by the signature checker and its serial unload path.
package bist_pkg;

  localparam int N_SIG       = 64;
  localparam int N_SESS      = 16;
  localparam int SESS_ADDR_W = 4;

  typedef enum logic [2:0] {
    COLLECT,
    COMPARE,
    REPORT,
    UNLOAD,
    DONE
  } chk_state_t;

endpackage

// File: rtl/bist_ser_tx.sv
// LSB-first parallel-load serializer with valid/ready/last.
// One frame per load; valid drops after the last bit is accepted.
module bist_ser_tx #(
  parameter int W = 80
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] data_i,
  input  logic         ready_i,
  output logic         data_o,
  output logic         valid_o,
  output logic         last_o,
  output logic         done_o
);

  localparam int CW = $clog2(W);

  logic [W-1:0]  sh_q, sh_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          vld_q, vld_d;
  logic          hs, last;

  assign last = vld_q && (cnt_q == CW'(W-1));
  assign hs   = vld_q && ready_i;

  always_comb begin
    sh_d  = sh_q;
    cnt_d = cnt_q;
    vld_d = vld_q;
    if (load_i) begin
      sh_d  = data_i;
      cnt_d = '0;
      vld_d = 1'b1;
    end else if (hs) begin
      sh_d = sh_q >> 1;
      if (last) vld_d = 1'b0;
      else      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_q  <= '0;
      cnt_q <= '0;
      vld_q <= 1'b0;
    end else begin
      sh_q  <= sh_d;
      cnt_q <= cnt_d;
      vld_q <= vld_d;
    end
  end

  assign data_o  = sh_q[0];
  assign valid_o = vld_q;
  assign last_o  = last;
  assign done_o  = hs && last;

endmodule

// File: rtl/bist_sig_checker.sv
// Per-session MISR signature compare against a golden ROM, fail-map
// tracking and serial unload of {final signature, fail map}.
module bist_sig_checker #(
  parameter int N      = bist_pkg::N_SIG,
  parameter int N_SESS = bist_pkg::N_SESS,
  parameter int ADDR_W = bist_pkg::SESS_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sess_done_i,
  input  logic [ADDR_W-1:0] sess_idx_i,
  input  logic [N-1:0]      misr_sig_i,
  output logic [ADDR_W-1:0] golden_addr_o,
  input  logic [N-1:0]      golden_i,
  input  logic              end_test_i,
  input  logic              unload_req_i,
  output logic              ser_data_o,
  output logic              ser_valid_o,
  input  logic              ser_ready_i,
  output logic              ser_last_o,
  output logic [N_SESS-1:0] fail_map_o,
  output logic [ADDR_W-1:0] first_fail_o,
  output logic              overrun_o,
  output logic              done_o,
  output logic              pass_o
);

  import bist_pkg::*;

  localparam int FW = N_SESS + N;

  chk_state_t        state_q, state_d;
  logic [N-1:0]      sig_q, sig_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] ff_q, ff_d;
  logic [N_SESS-1:0] map_q, map_d;
  logic              any_q, any_d;
  logic              ovr_q, ovr_d;
  logic              end_q, end_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic              mis, ld, tx_done;

  always_comb begin
    state_d = state_q;
    sig_d   = sig_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    ff_d    = ff_q;
    map_d   = map_q;
    any_d   = any_q;
    ovr_d   = ovr_q;
    end_d   = end_q;
    done_d  = done_q;
    pass_d  = pass_q;
    mis     = 1'b0;
    ld      = 1'b0;
    unique case (state_q)
      COLLECT: begin
        if (sess_done_i) begin
          sig_d   = misr_sig_i;
          idx_d   = sess_idx_i;
          addr_d  = sess_idx_i;
          end_d   = end_test_i;
          state_d = COMPARE;
        end else if (end_test_i) begin
          done_d  = 1'b1;
          pass_d  = (map_q == '0) && !ovr_q;
          state_d = REPORT;
        end
      end
      COMPARE: begin
        mis = (sig_q != golden_i);
        // out-of-range indices are compared but leave the map alone
        for (int i = 0; i < N_SESS; i++) begin
          if (idx_q == ADDR_W'(i)) map_d[i] = mis;
        end
        if (mis && !any_q) begin
          ff_d  = idx_q;
          any_d = 1'b1;
        end
        if (sess_done_i) ovr_d = 1'b1;
        if (end_q || end_test_i) begin
          end_d   = 1'b0;
          done_d  = 1'b1;
          pass_d  = (map_d == '0) && !ovr_d;
          state_d = REPORT;
        end else begin
          state_d = COLLECT;
        end
      end
      REPORT: begin
        if (unload_req_i) begin
          ld      = 1'b1;
          state_d = UNLOAD;
        end
      end
      UNLOAD: begin
        if (tx_done) state_d = DONE;
      end
      DONE: begin
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= COLLECT;
      sig_q   <= '0;
      idx_q   <= '0;
      addr_q  <= '0;
      ff_q    <= '0;
      map_q   <= '0;
      any_q   <= 1'b0;
      ovr_q   <= 1'b0;
      end_q   <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sig_q   <= sig_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      ff_q    <= ff_d;
      map_q   <= map_d;
      any_q   <= any_d;
      ovr_q   <= ovr_d;
      end_q   <= end_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  bist_ser_tx #(
    .W(FW)
  ) u_tx (
    .clk    (clk),
    .rst    (rst),
    .load_i (ld),
    .data_i ({sig_q, map_q}),
    .ready_i(ser_ready_i),
    .data_o (ser_data_o),
    .valid_o(ser_valid_o),
    .last_o (ser_last_o),
    .done_o (tx_done)
  );

  assign golden_addr_o = addr_q;
  assign fail_map_o    = map_q;
  assign first_fail_o  = ff_q;
  assign overrun_o     = ovr_q;
  assign done_o        = done_q;
  assign pass_o        = pass_q;

endmodule
